// File: rtl/segment_if_id_skid_if.sv
// Valid/ready bundle carrying one fetched instruction (pc + instr).
// master drives valid/pc/instr and samples ready; slave is the reverse.
interface segment_if_id_skid_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;

  modport master (
    output valid, pc, instr,
    input  ready
  );

  modport slave (
    input  valid, pc, instr,
    output ready
  );
endinterface

// File: rtl/segment_if_id_skid.sv
// IF/ID segment: valid/ready, optional 2-entry skid, flush, stall counter.
// Ports: clk (falling-edge), rst (async, high), flush, in_if (slave,
// from fetch), out_if (master, to decode), stall_cnt (saturating).
module segment_if_id_skid #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  segment_if_id_skid_if.slave     in_if,
  segment_if_id_skid_if.master    out_if,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] main_pc, main_pc_n;
  logic [DATA_W-1:0] main_in, main_in_n;
  logic [ADDR_W-1:0] skid_pc, skid_pc_n;
  logic [DATA_W-1:0] skid_in, skid_in_n;

  logic in_fire, out_fire, out_valid;

  assign out_valid = (state != EMPTY);

  // SKID=1: ready depends on state only, so it is a registered path.
  // SKID=0: ready looks through to decode's ready.
  always_comb begin
    if (SKID)
      in_if.ready = !rst && (state != TWO);
    else
      in_if.ready = !rst && (!out_valid || out_if.ready);
  end

  assign in_fire  = in_if.valid && in_if.ready;
  assign out_fire = out_valid && out_if.ready;

  assign out_if.valid = out_valid;
  assign out_if.pc    = main_pc;
  assign out_if.instr = main_in;

  // main regs are zeroed whenever the segment drains, so an idle
  // output is an all-zero bubble without extra muxing.
  always_comb begin
    state_n   = state;
    main_pc_n = main_pc;
    main_in_n = main_in;
    skid_pc_n = skid_pc;
    skid_in_n = skid_in;
    if (flush) begin
      state_n   = EMPTY;
      main_pc_n = '0;
      main_in_n = '0;
      skid_pc_n = '0;
      skid_in_n = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_pc_n = in_if.pc;
            main_in_n = in_if.instr;
            state_n   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc_n = in_if.pc;
            main_in_n = in_if.instr;
          end else if (in_fire && SKID) begin
            skid_pc_n = in_if.pc;
            skid_in_n = in_if.instr;
            state_n   = TWO;
          end else if (out_fire) begin
            main_pc_n = '0;
            main_in_n = '0;
            state_n   = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_pc_n = skid_pc;
            main_in_n = skid_in;
            skid_pc_n = '0;
            skid_in_n = '0;
            state_n   = ONE;
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_pc <= '0;
      main_in <= '0;
      skid_pc <= '0;
      skid_in <= '0;
    end else begin
      state   <= state_n;
      main_pc <= main_pc_n;
      main_in <= main_in_n;
      skid_pc <= skid_pc_n;
      skid_in <= skid_in_n;
    end
  end

  // Counts stalled edges even while flushing; only rst clears it.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_if.ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_segment_if_id_skid.sv
// Bench for segment_if_id_skid: SKID=1/CNT_W=4 and SKID=0 instances
// driven in lockstep, each checked against its own FIFO scoreboard.
module tb_segment_if_id_skid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk   = 1'b1;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic        vin   = 1'b0;
  logic        ordy  = 1'b0;
  logic [31:0] pc    = '0;
  logic [31:0] instr = '0;
  logic [3:0]  sc1;
  logic [15:0] sc0;

  segment_if_id_skid_if fi1 ();
  segment_if_id_skid_if fo1 ();
  segment_if_id_skid_if fi0 ();
  segment_if_id_skid_if fo0 ();

  assign fi1.valid = vin;
  assign fi1.pc    = pc;
  assign fi1.instr = instr;
  assign fo1.ready = ordy;
  assign fi0.valid = vin;
  assign fi0.pc    = pc;
  assign fi0.instr = instr;
  assign fo0.ready = ordy;

  segment_if_id_skid #(
    .SKID (1'b1),
    .CNT_W(4)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_if    (fi1),
    .out_if   (fo1),
    .stall_cnt(sc1)
  );

  segment_if_id_skid #(
    .SKID (1'b0),
    .CNT_W(16)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_if    (fi0),
    .out_if   (fo0),
    .stall_cnt(sc0)
  );

  always #5 clk = ~clk;

  ent_t q1[$];
  ent_t q0[$];
  int   s1, s0;
  int   n_tests, n_fail;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    ent_t h1, h0;
    logic f1i, f1o, f0i, f0o;
    #1;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    check("rdy1",   64'(fi1.ready), 64'(q1.size() < 2));
    check("val1",   64'(fo1.valid), 64'(q1.size() > 0));
    check("pc1",    64'(fo1.pc),    64'(h1.pc));
    check("ins1",   64'(fo1.instr), 64'(h1.instr));
    check("stall1", 64'(sc1),       64'(s1));
    check("rdy0",   64'(fi0.ready), 64'(q0.size() == 0 || ordy));
    check("val0",   64'(fo0.valid), 64'(q0.size() > 0));
    check("pc0",    64'(fo0.pc),    64'(h0.pc));
    check("ins0",   64'(fo0.instr), 64'(h0.instr));
    check("stall0", 64'(sc0),       64'(s0));
    f1i = vin && (q1.size() < 2);
    f1o = (q1.size() > 0) && ordy;
    f0i = vin && (q0.size() == 0 || ordy);
    f0o = (q0.size() > 0) && ordy;
    if (q1.size() > 0 && !ordy && s1 < 15)    s1++;
    if (q0.size() > 0 && !ordy && s0 < 65535) s0++;
    @(negedge clk);
    #1;
    if (f1o) void'(q1.pop_front());
    if (f0o) void'(q0.pop_front());
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f1i) q1.push_back({pc, instr});
      if (f0i) q0.push_back({pc, instr});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p,
                       input logic [31:0] i, input logic r,
                       input logic f);
    vin   = v;
    pc    = p;
    instr = i;
    ordy  = r;
    flush = f;
    step();
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_rdy1"}, 64'(fi1.ready), 64'(0));
    check({tag, "_val1"}, 64'(fo1.valid), 64'(0));
    check({tag, "_pc1"},  64'(fo1.pc),    64'(0));
    check({tag, "_ins1"}, 64'(fo1.instr), 64'(0));
    check({tag, "_sc1"},  64'(sc1),       64'(0));
    check({tag, "_rdy0"}, 64'(fi0.ready), 64'(0));
    check({tag, "_val0"}, 64'(fo0.valid), 64'(0));
    check({tag, "_sc0"},  64'(sc0),       64'(0));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    s1      = 0;
    s0      = 0;
    #2;
    rst_checks("por");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // streaming with decode always ready
    drive(1'b1, 32'h0, 32'hA000_0001, 1'b1, 1'b0);
    drive(1'b1, 32'h4, 32'hA000_0002, 1'b1, 1'b0);
    drive(1'b1, 32'h8, 32'hA000_0003, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // backpressure fills the skid; then drain in order
    drive(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 32'hB000_0014, 1'b0, 1'b0);
    drive(1'b1, 32'h18, 32'hB000_0018, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush while full with a pending input
    drive(1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 32'hC000_0024, 1'b0, 1'b0);
    drive(1'b1, 32'h18, 32'hC000_0018, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush coinciding with a consume, and with an accepted input
    drive(1'b1, 32'h28, 32'hC000_0028, 1'b1, 1'b0);
    drive(1'b1, 32'h2C, 32'hC000_002C, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // stall counter saturation, survives flush
    drive(1'b1, 32'h40, 32'hD000_0040, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("stall_sat", 64'(sc1), 64'(15));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stall_keep", 64'(sc1), 64'(15));

    // async reset between edges mid-stream
    drive(1'b1, 32'h50, 32'hE000_0050, 1'b1, 1'b0);
    drive(1'b1, 32'h54, 32'hE000_0054, 1'b0, 1'b0);
    vin   = 1'b1;
    pc    = 32'h58;
    instr = 32'hE000_0058;
    #2;
    rst = 1'b1;
    #1;
    rst_checks("arst");
    q1.delete();
    q0.delete();
    s1 = 0;
    s0 = 0;
    #1;
    rst = 1'b0;
    #1;

    // resume after reset
    drive(1'b1, 32'h60, 32'hF000_0060, 1'b1, 1'b0);
    drive(1'b1, 32'h64, 32'hF000_0064, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
